pa_param_loader: RTL and testbench

Sequencer that fills the per-channel requantization buffers of the PE-array top (shift, multiplier and bias, 32 bits × 16 channels each) from the shared 32-bit memory read port before a layer runs. On `start` it walks the selected parameter arrays in a fixed order, fetching one word per channel through the memory read handshake. It drives the top's `buf_wr` / `buf_wr_sel` / channel-index write port, and issues a one-cycle `pa_start` to launch the PE-array state machine once loading is complete.

---
 rtl/pa_param_loader.sv | 101 ++++++++++
 tb/tb_pa_param_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pa_param_loader.sv
// pa_param_loader: fills the shift/multiplier/bias requant buffers from memory, then launches the PE array
//   clk, rst_n                       clock, async active-low reset
//   start, load_mask, ch_count       load request; mask bit0 shifts, bit1 multipliers, bit2 bias
//   shift_base, multi_base, bias_base byte base address of each parameter array
//   mem_req, mem_addr, read_rdy, read_acq, data   memory read handshake
//   buf_wr, buf_wr_sel, buf_idx, buf_wdata        buffer write port
//   busy, pa_start                   loader active, one-cycle PE-array launch
module pa_param_loader #(
  parameter int NUM_CH = 16,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2:0]    load_mask,
  input  logic [31:0]   ch_count,
  input  logic [AW-1:0] shift_base,
  input  logic [AW-1:0] multi_base,
  input  logic [AW-1:0] bias_base,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          read_rdy,
  output logic          read_acq,
  input  logic [31:0]   data,
  output logic          buf_wr,
  output logic [1:0]    buf_wr_sel,
  output logic [3:0]    buf_idx,
  output logic [31:0]   buf_wdata,
  output logic          busy,
  output logic          pa_start
);
  typedef enum logic [1:0] {IDLE, FETCH, WRITE, GO} state_t;
  state_t state, state_nx;
  logic [2:0] mask;
  logic [AW-1:0] sbase, mbase, bbase, base;
  logic [4:0] n, n_in;
  logic [1:0] sel, first_sel, next_sel;
  logic [3:0] idx;
  logic last, has_next;
  always_comb begin
    n_in = (ch_count > 32'(NUM_CH)) ? 5'(NUM_CH) : ch_count[4:0];
    first_sel = load_mask[0] ? 2'd0 : load_mask[1] ? 2'd1 : 2'd2;
    has_next = (sel == 2'd0) ? |mask[2:1] : (sel == 2'd1) && mask[2];
    next_sel = (sel == 2'd0 && mask[1]) ? 2'd1 : 2'd2;
    // idx < n-1 written without subtraction so n == 1 needs no special case
    last = ({1'b0, idx} + 5'd1) >= n;
    base = (sel == 2'd0) ? sbase : (sel == 2'd1) ? mbase : bbase;
    mem_addr = (state == FETCH) ? base + AW'({idx, 2'b00}) : '0;
    busy = state != IDLE;
    mem_req = state == FETCH;
    read_acq = state == FETCH;
    buf_wr = state == WRITE;
    pa_start = state == GO;
    state_nx = state;
    case (state)
      IDLE:  state_nx = !start ? IDLE : (n_in == 5'd0 || load_mask == 3'd0) ? GO : FETCH;
      FETCH: state_nx = read_rdy ? WRITE : FETCH;
      WRITE: state_nx = (!last || has_next) ? FETCH : GO;
      GO:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mask <= '0;
      sbase <= '0;
      mbase <= '0;
      bbase <= '0;
      n <= '0;
      sel <= '0;
      idx <= '0;
      buf_wr_sel <= '0;
      buf_idx <= '0;
      buf_wdata <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        mask <= load_mask;
        sbase <= shift_base;
        mbase <= multi_base;
        bbase <= bias_base;
        n <= n_in;
        sel <= first_sel;
        idx <= '0;
      end
      // write-port fields are captured with the data so they hold between writes
      if (state == FETCH && read_rdy) begin
        buf_wdata <= data;
        buf_wr_sel <= sel;
        buf_idx <= idx;
      end
      if (state == WRITE) begin
        if (!last) idx <= idx + 4'd1;
        else if (has_next) begin
          sel <= next_sel;
          idx <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_pa_param_loader.sv
// tb_pa_param_loader: scoreboard bench for pa_param_loader
module tb_pa_param_loader;
  logic clk, rst_n, start, mem_req, read_rdy, read_acq, buf_wr, busy, pa_start;
  logic [2:0] load_mask;
  logic [31:0] ch_count, shift_base, multi_base, bias_base, mem_addr, data, buf_wdata;
  logic [1:0] buf_wr_sel;
  logic [3:0] buf_idx;
  int checks = 0, errors = 0;
  int ncyc = 0, t0 = 0, pa_count = 0, pa_cyc = 0, mreq_count = 0, wr_count = 0;
  int wait_n = 0;
  logic [37:0] sb_q[$];

  pa_param_loader #(.NUM_CH(16), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_mask(load_mask), .ch_count(ch_count),
    .shift_base(shift_base), .multi_base(multi_base), .bias_base(bias_base),
    .mem_req(mem_req), .mem_addr(mem_addr), .read_rdy(read_rdy), .read_acq(read_acq),
    .data(data), .buf_wr(buf_wr), .buf_wr_sel(buf_wr_sel), .buf_idx(buf_idx),
    .buf_wdata(buf_wdata), .busy(busy), .pa_start(pa_start)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  // memory model: returns data = address after wait_n wait cycles, checks address stability
  initial begin
    int wcnt;
    logic [31:0] held;
    wcnt = 0;
    held = 0;
    read_rdy = 0;
    data = 0;
    forever begin
      @(negedge clk);
      if (mem_req && rst_n) begin
        if (wcnt > 0) begin
          checks++;
          if (mem_addr !== held) begin
            errors++;
            $display("FAIL addr_stable got %h expected %h", mem_addr, held);
          end
        end
        held = mem_addr;
        if (wcnt == wait_n) begin
          read_rdy = 1;
          data = mem_addr;
          wcnt = 0;
        end else begin
          read_rdy = 0;
          wcnt++;
        end
      end else begin
        read_rdy = 0;
        wcnt = 0;
      end
    end
  end

  // output monitor: pops the scoreboard on each buffer write
  initial begin
    logic [37:0] e;
    forever begin
      @(negedge clk);
      if (mem_req) mreq_count++;
      if (pa_start) begin
        pa_count++;
        pa_cyc = ncyc - t0 + 1;
      end
      if (buf_wr) begin
        wr_count++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_wr got sel=%0d idx=%0d data=%h expected no write", buf_wr_sel, buf_idx, buf_wdata);
        end else begin
          e = sb_q.pop_front();
          if ({buf_wr_sel, buf_idx, buf_wdata} !== e) begin
            errors++;
            $display("FAIL buf_write got sel=%0d idx=%0d data=%h expected sel=%0d idx=%0d data=%h",
                     buf_wr_sel, buf_idx, buf_wdata, e[37:36], e[35:32], e[31:0]);
          end
        end
      end
    end
  end

  task automatic start_load(input logic [2:0] m, input logic [31:0] c, input logic [31:0] sb,
                            input logic [31:0] mb, input logic [31:0] bb, input int w);
    int n;
    logic [31:0] bs [3];
    bs[0] = sb; bs[1] = mb; bs[2] = bb;
    n = (c > 16) ? 16 : int'(c);
    for (int b = 0; b < 3; b++)
      if (m[b]) for (int i = 0; i < n; i++) sb_q.push_back({2'(b), 4'(i), bs[b] + 32'(4 * i)});
    @(negedge clk);
    pa_count = 0; mreq_count = 0; wr_count = 0; wait_n = w;
    load_mask = m; ch_count = c; shift_base = sb; multi_base = mb; bias_base = bb;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    t0 = ncyc;
  endtask

  task automatic finish_load(input string name, input int exp_pa, input int exp_wr);
    int lim, idle_cyc;
    lim = 0;
    @(negedge clk);
    while (busy && lim < 3000) begin
      @(negedge clk);
      lim++;
    end
    idle_cyc = ncyc - t0 + 1;
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_timeout busy still 1 after %0d cycles, expected idle", name, lim);
    end
    checks++;
    if (pa_count !== 1 || pa_cyc !== exp_pa) begin
      errors++;
      $display("FAIL %s_pa_start got count=%0d cycle=%0d expected count=1 cycle=%0d", name, pa_count, pa_cyc, exp_pa);
    end
    checks++;
    if (idle_cyc !== exp_pa + 1) begin
      errors++;
      $display("FAIL %s_idle got cycle %0d expected %0d", name, idle_cyc, exp_pa + 1);
    end
    checks++;
    if (wr_count !== exp_wr || sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_writes got %0d pending=%0d expected %0d pending=0", name, wr_count, sb_q.size(), exp_wr);
    end
    sb_q.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({busy, mem_req, read_acq, buf_wr, pa_start, buf_wr_sel, buf_idx, buf_wdata, mem_addr} !== '0) begin
      errors++;
      $display("FAIL %s got busy=%b req=%b acq=%b wr=%b pa=%b sel=%0d idx=%0d wdata=%h addr=%h expected all 0",
               name, busy, mem_req, read_acq, buf_wr, pa_start, buf_wr_sel, buf_idx, buf_wdata, mem_addr);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; load_mask = 0; ch_count = 0;
    shift_base = 0; multi_base = 0; bias_base = 0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_state");
    rst_n = 1;
    repeat (2) @(negedge clk);
    check_idle_outputs("post_reset_idle");
  endtask

  task automatic test_full();
    start_load(3'b111, 16, 32'h100, 32'h200, 32'h300, 0);
    finish_load("full", 97, 48);
  endtask

  task automatic test_wait();
    start_load(3'b100, 5, 32'h100, 32'h200, 32'h300, 2);
    finish_load("wait", 21, 5);
  endtask

  task automatic test_clamp();
    start_load(3'b011, 40, 32'hFFFF_FFF0, 32'h4000, 32'h0, 0);
    finish_load("clamp40", 65, 32);
    start_load(3'b001, 32'h1000_0003, 32'h80, 32'h0, 32'h0, 0);
    finish_load("clamp_hi", 33, 16);
  endtask

  task automatic test_degenerate();
    start_load(3'b111, 0, 32'h100, 32'h200, 32'h300, 0);
    finish_load("n0", 1, 0);
    checks++;
    if (mreq_count !== 0) begin errors++; $display("FAIL n0_mem_req got %0d expected 0", mreq_count); end
    start_load(3'b000, 8, 32'h100, 32'h200, 32'h300, 0);
    finish_load("mask0", 1, 0);
    checks++;
    if (mreq_count !== 0) begin errors++; $display("FAIL mask0_mem_req got %0d expected 0", mreq_count); end
  endtask

  task automatic test_back_to_back();
    start_load(3'b101, 4, 32'h1000, 32'h2000, 32'h3000, 1);
    repeat (3) @(negedge clk);
    start = 1;
    repeat (4) @(negedge clk);
    start = 0;
    finish_load("restart_ignored", 25, 8);
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      logic [2:0] m;
      int c, w, n;
      m = 3'($urandom_range(0, 7));
      c = $urandom_range(0, 20);
      w = $urandom_range(0, 2);
      n = (c > 16) ? 16 : c;
      start_load(m, 32'(c), $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, w);
      finish_load("random", $countones(m) * n * (2 + w) + 1, $countones(m) * n);
    end
  endtask

  task automatic test_reset_mid();
    int lim;
    start_load(3'b001, 16, 32'h500, 32'h0, 32'h0, 0);
    lim = 0;
    while (wr_count < 7 && lim < 200) begin
      @(posedge clk);
      lim++;
    end
    #2 rst_n = 0;
    #1 check_idle_outputs("reset_mid_async");
    sb_q.delete();
    repeat (4) @(negedge clk);
    checks++;
    if (pa_count !== 0 || wr_count !== 7) begin
      errors++;
      $display("FAIL reset_mid_abort got pa=%0d writes=%0d expected pa=0 writes=7", pa_count, wr_count);
    end
    rst_n = 1;
    start_load(3'b011, 3, 32'h500, 32'h600, 32'h0, 0);
    finish_load("after_reset", 13, 6);
  endtask

  initial begin
    test_reset();
    test_full();
    test_wait();
    test_clamp();
    test_degenerate();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
